multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the LEGv8 datapath (PC, instruction memory, register file, ALU, data memory, branch mux).
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and strobe.
//  Waits on a data-memory ready handshake. Flags illegal opcodes and memory timeouts. Counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_RD/MEM_WR without mem_ready before ERROR
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clock        in   1      single system clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  Opcode       in   11     Instruction[31:21] from the latched IR
//  Zero         in   1      ALU zero flag (combinational, current cycle)
//  mem_ready    in   1      data memory has completed the current read/write
//  IRWrite      out  1      latch instruction memory output into IR
//  PCWrite      out  1      load PC this cycle
//  PCSrc        out  1      0 = PC+4, 1 = branch target (PC+4 + SE<<2)
//  Reg2Loc      out  1      0 = Read2 from [20:16], 1 = from [4:0]
//  ALUSrc       out  1      0 = register Data2, 1 = sign-extended immediate
//  ALUOp        out  2      00 add (address), 01 pass-B/CBZ, 10 R-type by opcode
//  MemRead      out  1      data memory read strobe, held until mem_ready
//  MemWrite     out  1      data memory write strobe, held until mem_ready
//  MemtoReg     out  1      0 = ALU result, 1 = memory data to register file
//  RegWrite     out  1      register file write enable
//  state        out  4      current FSM state, for debug
//  illegal      out  1      sticky: undecodable opcode seen
//  timeout      out  1      sticky: mem_ready not seen within MEM_TIMEOUT
//  retired      out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
//  - reset_n low (any time, mid-instruction included): state=INIT(0); all outputs 0; flags, counters cleared at once.
//  - States: INIT=0 FETCH=1 DECODE=2 EXEC_R=3 WB_R=4 ADDR=5 MEM_RD=6 WB_LD=7 MEM_WR=8 CBZ=9 BR=10 HALT=15.
//  - Outputs are a Moore decode of state. Exception: PCWrite in CBZ equals Zero (Mealy). Unlisted outputs are 0.
//  - INIT: no strobes. Next cycle -> FETCH.
//  - FETCH: IRWrite=1, PCWrite=1, PCSrc=0. -> DECODE.
//  - DECODE: no strobes. Classify Opcode:
//      ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R
//      LDUR 11111000010, STUR 11111000000 -> ADDR
//      CBZ 10110100xxx -> CBZ; B 000101xxxxx -> BR; anything else -> HALT, illegal=1.
//  - EXEC_R: ALUSrc=0, Reg2Loc=0, ALUOp=10. -> WB_R.
//  - WB_R: as EXEC_R plus RegWrite=1, MemtoReg=0. -> FETCH, retire.
//  - ADDR: ALUSrc=1, ALUOp=00. Reg2Loc=1 if STUR. -> MEM_RD (LDUR) or MEM_WR (STUR). Clear wait counter.
//  - MEM_RD: ALUSrc=1, ALUOp=00, MemRead=1.
//      mem_ready=1 -> WB_LD.
//      Else counter++; counter==MEM_TIMEOUT-1 with no ready -> HALT, timeout=1.
//  - WB_LD: ALUSrc=1, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1. -> FETCH, retire.
//  - MEM_WR: ALUSrc=1, ALUOp=00, Reg2Loc=1, MemWrite=1.
//      mem_ready=1 -> FETCH, retire.
//      Timeout handled as in MEM_RD.
//  - mem_ready is sampled only in MEM_RD/MEM_WR and ignored elsewhere. Ready on the first MEM cycle gives 1-cycle memory access.
//  - CBZ: Reg2Loc=1, ALUSrc=0, ALUOp=01, PCSrc=1, PCWrite=Zero. -> FETCH, retire (taken or not).
//  - BR: PCWrite=1, PCSrc=1; Zero ignored. -> FETCH, retire.
//  - HALT: all strobes 0. Stays until reset_n. Both illegal and timeout may be 1 only if set by separate events (impossible in one run).
//  - Cycles per instruction: R 4, LDUR 5+w, STUR 4+w, CBZ 3, B 3 (w = wait cycles before mem_ready).
//  - retired increments by 1 on each retire transition, modulo 2^CNT_W. It is not incremented when entering HALT.
// TESTING
//  - Reset then ADD (Opcode 10001011000): states 0,1,2,3,4,1. RegWrite=1 only in state 4. retired=1.
//  - LDUR, mem_ready low 3 cycles then high: MemRead high for 4 cycles, then WB_LD with MemtoReg=1. retired=1.
//  - CBZ with Zero=1 -> PCWrite=1, PCSrc=1 in state 9. Zero=0 -> PCWrite=0. Both retire.
//  - STUR, mem_ready never high, MEM_TIMEOUT=16: HALT after 16 MEM_WR cycles, timeout=1, MemWrite=0 after.
//  - Opcode 11111111111 -> HALT, illegal=1. reset_n pulsed low mid-MEM_RD -> all outputs 0 immediately, state 0.
//  - CNT_W=4, 17 B instructions -> retired=1 (wrap). Each takes 3 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for a LEGv8 datapath. Each instruction moves through
// FETCH/DECODE/EXEC/MEM/WB and this block drives every datapath select and strobe.
// It waits on a data-memory ready handshake, flags undecodable opcodes and memory
// timeouts, and counts retired instructions.
//
// Ports:
//   clock, reset_n      system clock (rising edge), asynchronous active-low reset
//   Opcode[10:0]        Instruction[31:21] from the latched IR
//   Zero                ALU zero flag for the current cycle
//   mem_ready           data memory finished the current read/write
//   IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, ALUOp[1:0],
//   MemRead, MemWrite, MemtoReg, RegWrite   datapath controls
//   state[3:0]          current FSM state (debug)
//   illegal, timeout    sticky error flags
//   retired[CNT_W-1:0]  retired-instruction count, wraps
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_LD  = 4'd7,
    S_MEM_WR = 4'd8,
    S_CBZ    = 4'd9,
    S_BR     = 4'd10,
    S_HALT   = 4'd15
  } state_e;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg2loc;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               store_q, store_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               wait_last;

  assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next state, flags, counters, and registered Moore decode of the next state
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    ctrl_d    = '0;

    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        casez (Opcode)
          11'b10001011000,
          11'b11001011000,
          11'b10001010000,
          11'b10101010000: state_d = S_EXEC_R;
          11'b11111000010: begin state_d = S_ADDR; store_d = 1'b0; end
          11'b11111000000: begin state_d = S_ADDR; store_d = 1'b1; end
          11'b10110100???: state_d = S_CBZ;
          11'b000101?????: state_d = S_BR;
          default: begin state_d = S_HALT; illegal_d = 1'b1; end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDR: begin
        state_d = store_q ? S_MEM_WR : S_MEM_RD;
        wait_d  = '0;
      end
      S_MEM_RD: begin
        if (mem_ready)      state_d = S_WB_LD;
        else if (wait_last) begin state_d = S_HALT; timeout_d = 1'b1; end
        else                wait_d = wait_q + WAIT_W'(1);
      end
      S_WB_LD:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_WR: begin
        if (mem_ready)      begin state_d = S_FETCH; retire = 1'b1; end
        else if (wait_last) begin state_d = S_HALT; timeout_d = 1'b1; end
        else                wait_d = wait_q + WAIT_W'(1);
      end
      S_CBZ:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BR:     begin state_d = S_FETCH; retire = 1'b1; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    // Outputs are decoded from the state being entered so they line up with it
    case (state_d)
      S_FETCH:  begin ctrl_d.ir_write = 1'b1; ctrl_d.pc_write = 1'b1; end
      S_EXEC_R: ctrl_d.alu_op = 2'b10;
      S_WB_R:   begin ctrl_d.alu_op = 2'b10; ctrl_d.reg_write = 1'b1; end
      S_ADDR:   begin ctrl_d.alu_src = 1'b1; ctrl_d.reg2loc = store_d; end
      S_MEM_RD: begin ctrl_d.alu_src = 1'b1; ctrl_d.mem_read = 1'b1; end
      S_WB_LD: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg2loc   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      // PCWrite for CBZ comes from the live Zero flag, added below
      S_CBZ:    begin ctrl_d.reg2loc = 1'b1; ctrl_d.alu_op = 2'b01; ctrl_d.pc_src = 1'b1; end
      S_BR:     begin ctrl_d.pc_write = 1'b1; ctrl_d.pc_src = 1'b1; end
      default:  ctrl_d = '0;
    endcase
  end

  // State, control and bookkeeping registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      ctrl_q    <= '0;
      store_q   <= 1'b0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      store_q   <= store_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign IRWrite  = ctrl_q.ir_write;
  assign PCWrite  = ctrl_q.pc_write | ((state_q == S_CBZ) & Zero);
  assign PCSrc    = ctrl_q.pc_src;
  assign Reg2Loc  = ctrl_q.reg2loc;
  assign ALUSrc   = ctrl_q.alu_src;
  assign ALUOp    = ctrl_q.alu_op;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into the state
// trace it should produce, then driven cycle by cycle with random Zero/mem_ready.
module tb_multicycle_controller;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 4;

  localparam int ST_INIT = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_WB_R = 4,
                 ST_ADDR = 5, ST_MEM_RD = 6, ST_WB_LD = 7, ST_MEM_WR = 8, ST_CBZ = 9,
                 ST_BR = 10, ST_HALT = 15;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [10:0]      Opcode = '0;
  logic             Zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
  logic [1:0]       ALUOp;
  logic             MemRead, MemWrite, MemtoReg, RegWrite;
  logic [3:0]       state;
  logic             illegal, timeout;
  logic [CNT_W-1:0] retired;
  logic [10:0]      outs;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_retired = 0;
  bit          m_ill = 1'b0;
  bit          m_to  = 1'b0;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clock = ~clock;

  assign outs = {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, ALUOp,
                 MemRead, MemWrite, MemtoReg, RegWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Control outputs each state should present: {IRW,PCW,PCSrc,R2L,ALUSrc,ALUOp,MR,MW,M2R,RW}
  function automatic logic [10:0] exp_outs(input int st, input bit store, input bit z);
    logic ir, pw, ps, r2, as, mr, mw, m2r, rw;
    logic [1:0] op;
    {ir, pw, ps, r2, as, mr, mw, m2r, rw} = '0;
    op = 2'b00;
    case (st)
      ST_FETCH:  begin ir = 1; pw = 1; end
      ST_EXEC_R: op = 2'b10;
      ST_WB_R:   begin op = 2'b10; rw = 1; end
      ST_ADDR:   begin as = 1; r2 = store; end
      ST_MEM_RD: begin as = 1; mr = 1; end
      ST_WB_LD:  begin as = 1; mr = 1; m2r = 1; rw = 1; end
      ST_MEM_WR: begin as = 1; r2 = 1; mw = 1; end
      ST_CBZ:    begin r2 = 1; op = 2'b01; ps = 1; pw = z; end
      ST_BR:     begin pw = 1; ps = 1; end
      default:   ;
    endcase
    return {ir, pw, ps, r2, as, op, mr, mw, m2r, rw};
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) return K_R;
    if (op == OP_LDUR) return K_LD;
    if (op == OP_STUR) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  task automatic check_all(input string tag, input int st, input bit store, input bit z);
    check({tag, ".state"},   32'(state),   32'(st));
    check({tag, ".ctrl"},    32'(outs),    32'(exp_outs(st, store, z)));
    check({tag, ".retired"}, 32'(retired), m_retired);
    check({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // One clock: drive inputs on the falling edge, check shortly after
  task automatic step(input string tag, input int st, input bit store,
                      input bit z, input bit mr, input logic [10:0] op);
    @(negedge clock);
    Zero = z;
    mem_ready = mr;
    Opcode = op;
    #1;
    check_all(tag, st, store, z);
  endtask

  // mid=1 asserts reset between clock edges, partway through a cycle
  task automatic do_reset(input bit mid);
    if (mid) #2;
    else @(negedge clock);
    reset_n = 1'b0;
    Zero = 1'b1;
    mem_ready = 1'b1;
    m_retired = 0;
    m_ill = 1'b0;
    m_to = 1'b0;
    #1;
    check_all(mid ? "rst_mid" : "rst", ST_INIT, 1'b0, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_all("init", ST_INIT, 1'b0, 1'b1);
  endtask

  // Expand one instruction into its expected state trace and run it.
  // w = wait cycles before mem_ready; zf < 0 means random Zero.
  task automatic run_instr(input logic [10:0] op, input int w, input int zf);
    int q[$];
    int kind, halt_ev, j;
    bit store, ret, z, mr;
    string tag;
    kind = classify(op);
    store = (kind == K_ST);
    halt_ev = 0;
    ret = 1'b0;
    q = '{ST_FETCH, ST_DECODE};
    case (kind)
      K_R:   begin q.push_back(ST_EXEC_R); q.push_back(ST_WB_R); ret = 1; end
      K_LD, K_ST: begin
        q.push_back(ST_ADDR);
        for (int i = 0; i < ((w < int'(MEM_TIMEOUT)) ? w + 1 : int'(MEM_TIMEOUT)); i++)
          q.push_back(store ? ST_MEM_WR : ST_MEM_RD);
        if (w < int'(MEM_TIMEOUT)) begin
          if (!store) q.push_back(ST_WB_LD);
          ret = 1;
        end else begin
          halt_ev = 2;
        end
      end
      K_CBZ: begin q.push_back(ST_CBZ); ret = 1; end
      K_B:   begin q.push_back(ST_BR); ret = 1; end
      default: halt_ev = 1;
    endcase
    if (halt_ev != 0)
      for (int i = 0; i < 4; i++) q.push_back(ST_HALT);
    j = 0;
    foreach (q[i]) begin
      z = (zf < 0) ? 1'($urandom) : 1'(zf);
      if (q[i] == ST_MEM_RD || q[i] == ST_MEM_WR) begin
        mr = (j == w);
        j++;
      end else begin
        mr = 1'($urandom);
      end
      if (q[i] == ST_HALT) begin
        if (halt_ev == 1) m_ill = 1'b1;
        else m_to = 1'b1;
      end
      tag = $sformatf("op%b.c%0d", op, i);
      step(tag, q[i], store, z, mr, op);
    end
    if (ret) m_retired = (m_retired + 1) % (32'd1 << CNT_W);
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] op;
    case ($urandom_range(0, 7))
      0: op = OP_ADD;
      1: op = OP_SUB;
      2: op = OP_AND;
      3: op = OP_ORR;
      4: op = OP_LDUR;
      5: op = OP_STUR;
      6: op = {8'b10110100, 3'($urandom)};
      default: op = {6'b000101, 5'($urandom)};
    endcase
    return op;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] op;

    // Reset, then the basic instruction classes
    do_reset(1'b0);
    run_instr(OP_ADD, 0, -1);
    run_instr(OP_LDUR, 3, -1);
    run_instr({8'b10110100, 3'b101}, 0, 1);
    run_instr({8'b10110100, 3'b010}, 0, 0);
    run_instr(OP_STUR, 0, -1);
    run_instr(OP_LDUR, 0, -1);
    run_instr(OP_STUR, int'(MEM_TIMEOUT) - 1, -1);
    run_instr(OP_LDUR, int'(MEM_TIMEOUT) - 1, -1);

    // Random legal instruction stream
    for (int n = 0; n < 60; n++) begin
      op = rand_op();
      run_instr(op, $urandom_range(0, 5), -1);
    end

    // Counter wrap with 17 branches
    do_reset(1'b0);
    for (int n = 0; n < 17; n++) run_instr({6'b000101, 5'($urandom)}, 0, -1);
    step("wrap", ST_FETCH, 1'b0, 1'b0, 1'b0, OP_ADD);
    check("wrap.retired", 32'(retired), 32'd1);

    // Illegal opcodes
    do_reset(1'b0);
    run_instr(OP_ADD, 0, -1);
    run_instr(11'b11111111111, 0, -1);
    for (int n = 0; n < 3; n++) begin
      do_reset(1'b0);
      do op = 11'($urandom); while (classify(op) != K_ILL);
      run_instr(op, 0, -1);
    end

    // Store that never sees mem_ready
    do_reset(1'b0);
    run_instr(OP_STUR, 1000, -1);
    check("to.memwrite", 32'(MemWrite), 32'd0);

    // Load that never sees mem_ready
    do_reset(1'b0);
    run_instr(OP_LDUR, 1000, -1);

    // Reset pulsed in the middle of a load's memory wait
    do_reset(1'b0);
    run_instr(OP_ORR, 0, -1);
    step("mid.f", ST_FETCH,  1'b0, 1'b1, 1'b1, OP_LDUR);
    step("mid.d", ST_DECODE, 1'b0, 1'b1, 1'b1, OP_LDUR);
    step("mid.a", ST_ADDR,   1'b0, 1'b1, 1'b0, OP_LDUR);
    step("mid.m0", ST_MEM_RD, 1'b0, 1'b1, 1'b0, OP_LDUR);
    step("mid.m1", ST_MEM_RD, 1'b0, 1'b1, 1'b0, OP_LDUR);
    do_reset(1'b1);
    run_instr(OP_ADD, 0, -1);
    step("end", ST_FETCH, 1'b0, 1'b0, 1'b0, OP_SUB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
